// File: rtl/encoder.sv
// USB full-speed NRZI line encoder with idle (J) and EOP (SE0, SE0, J) generation.
// One bit per clock, never stalls. The line outputs are registered.
module encoder (
    input  logic clk,
    input  logic n_rst,
    input  logic Data_In,
    input  logic eop,
    input  logic idle,
    output logic d_plus,
    output logic d_minus
);

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        EOP2   = 2'd1,
        EOP3   = 2'd2
    } state_t;

    // Line levels packed as {d_plus, d_minus}.
    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    state_t state;
    state_t next_state;

    // NRZI reference: 1 = J, 0 = K.
    logic last;
    logic next_last;
    logic [1:0] next_line;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state   <= ACTIVE;
            last    <= 1'b1;
            d_plus  <= 1'b1;
            d_minus <= 1'b0;
        end else begin
            state   <= next_state;
            last    <= next_last;
            d_plus  <= next_line[1];
            d_minus <= next_line[0];
        end
    end

    // Once started, the EOP sequence runs to completion regardless of inputs.
    always_comb begin
        next_state = state;
        case (state)
            ACTIVE:  next_state = eop ? EOP2 : ACTIVE;
            EOP2:    next_state = EOP3;
            EOP3:    next_state = ACTIVE;
            default: next_state = ACTIVE;
        endcase
    end

    always_comb begin
        next_last = last;
        next_line = LINE_J;
        case (state)
            ACTIVE: begin
                if (eop) begin
                    next_line = LINE_SE0;
                end else if (idle) begin
                    next_last = 1'b1;
                    next_line = LINE_J;
                end else begin
                    // A 0 bit toggles the line, a 1 bit holds it.
                    next_last = Data_In ? last : ~last;
                    next_line = next_last ? LINE_J : LINE_K;
                end
            end
            EOP2: begin
                next_line = LINE_SE0;
            end
            EOP3: begin
                next_last = 1'b1;
                next_line = LINE_J;
            end
            default: begin
                next_last = 1'b1;
                next_line = LINE_J;
            end
        endcase
    end

endmodule

// File: tb/tb_encoder.sv
// Self-checking bench for the USB line encoder: a vector table for steady-state
// behaviour plus hand sequences for reset, including reset in the middle of an EOP.
module tb_encoder;

    localparam logic [1:0] J   = 2'b10;
    localparam logic [1:0] K   = 2'b01;
    localparam logic [1:0] SE0 = 2'b00;

    logic clk = 1'b0;
    logic n_rst;
    logic Data_In;
    logic eop;
    logic idle;
    logic d_plus;
    logic d_minus;

    int n_cmp = 0;
    int n_bad = 0;
    logic [1:0] exp_q[$];

    typedef struct {
        logic       rst_n;
        logic       eop;
        logic       idle;
        logic       data;
        logic [1:0] line;
    } vec_t;

    vec_t vecs[$];

    encoder dut (
        .clk     (clk),
        .n_rst   (n_rst),
        .Data_In (Data_In),
        .eop     (eop),
        .idle    (idle),
        .d_plus  (d_plus),
        .d_minus (d_minus)
    );

    always #5 clk = ~clk;

    task automatic add_vec(input logic r, input logic e, input logic i, input logic d,
                           input logic [1:0] line);
        vec_t v;
        v.rst_n = r;
        v.eop   = e;
        v.idle  = i;
        v.data  = d;
        v.line  = line;
        vecs.push_back(v);
    endtask

    task automatic check(input string name);
        logic [1:0] exp;
        logic [1:0] got;
        got = {d_plus, d_minus};
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s: got %b with no expected value queued", name, got);
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
                n_bad++;
                $display("FAIL %s: got {d_plus,d_minus}=%b required %b", name, got, exp);
            end
        end
    endtask

    // Drive at the falling edge, sample just after the following rising edge.
    task automatic drive(input logic r, input logic e, input logic i, input logic d,
                         input logic [1:0] line, input string name);
        @(negedge clk);
        n_rst   = r;
        eop     = e;
        idle    = i;
        Data_In = d;
        exp_q.push_back(line);
        @(posedge clk);
        #1;
        check(name);
    endtask

    initial begin
        n_rst   = 1'b0;
        eop     = 1'b0;
        idle    = 1'b0;
        Data_In = 1'b0;

        // Reset with random inputs: J after each reset edge.
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), J, $sformatf("reset_%0d", i));
        end

        // Sync byte 0000_0001 starting from J.
        for (int i = 0; i < 7; i++) add_vec(1, 0, 0, 0, (i % 2 == 0) ? K : J);
        add_vec(1, 0, 0, 1, K);
        // Idle from K with Data_In=0: J held.
        add_vec(1, 0, 1, 0, J);
        add_vec(1, 0, 1, 0, J);
        // Run of ones holds J, then a zero gives K.
        for (int i = 0; i < 6; i++) add_vec(1, 0, 0, 1, J);
        add_vec(1, 0, 0, 0, K);
        // EOP from K with toggling data, then first bit encoded relative to J.
        add_vec(1, 1, 0, 1, SE0);
        add_vec(1, 0, 0, 0, SE0);
        add_vec(1, 0, 0, 1, J);
        add_vec(1, 0, 0, 0, K);
        // Idle from K, then eop+idle together: eop wins; eop during EOP2/EOP3 ignored.
        add_vec(1, 0, 1, 0, J);
        add_vec(1, 0, 1, 0, J);
        add_vec(1, 0, 0, 0, K);
        add_vec(1, 1, 1, 0, SE0);
        add_vec(1, 1, 0, 0, SE0);
        add_vec(1, 1, 1, 0, J);
        add_vec(1, 0, 0, 1, J);
        add_vec(1, 0, 0, 0, K);
        add_vec(1, 0, 0, 0, J);

        foreach (vecs[n]) begin
            drive(vecs[n].rst_n, vecs[n].eop, vecs[n].idle, vecs[n].data, vecs[n].line,
                  $sformatf("vec_%0d", n));
        end

        // Reset on the EOP2 edge abandons the sequence and returns to J at once.
        drive(1, 0, 0, 0, K,   "mid_eop_pre");
        drive(1, 1, 0, 1, SE0, "mid_eop_se0");
        drive(0, 0, 0, 0, J,   "mid_eop_reset");
        drive(1, 0, 0, 1, J,   "mid_eop_after_1");
        drive(1, 0, 0, 1, J,   "mid_eop_after_2");
        drive(1, 0, 0, 0, K,   "mid_eop_after_3");

        // Reset from the EOP3 state as well.
        drive(1, 1, 0, 0, SE0, "eop3_se0_a");
        drive(1, 0, 0, 0, SE0, "eop3_se0_b");
        drive(0, 1, 1, 0, J,   "eop3_reset");
        drive(1, 0, 0, 0, K,   "eop3_after");

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL queue_drain: %0d expected values left, required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
